// File: rtl/mc_mem_pkg.sv
// Shared types and defaults for the MCU data memory controller.
// Holds the controller state encoding and the parameter legality check.
package mc_mem_pkg;

  typedef enum logic [0:0] {
    StClear = 1'b0,
    StIdle  = 1'b1
  } mem_state_e;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDepth = 256;

  // Depth must be at least two words and must fit inside the address space.
  function automatic bit depth_legal(input int unsigned depth, input int unsigned addr_w);
    longint unsigned span;
    span = longint'(1) << addr_w;
    return (depth >= 2) && (longint'(depth) <= span);
  endfunction

endpackage

// File: rtl/data_mem_ctl_if.sv
// Request/response bundle between the MCU control unit and the data memory.
// The master issues accesses and clears; the slave answers with ready/rdata/rvalid/err.
interface data_mem_ctl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) ();

  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              clr;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              err;

  modport master (
    output en, we, addr, wdata, clr,
    input  ready, rdata, rvalid, err
  );

  modport slave (
    input  en, we, addr, wdata, clr,
    output ready, rdata, rvalid, err
  );

endinterface

// File: rtl/mc_mem_array.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered read port.
// Storage is never reset; only the read register returns to zero.
module mc_mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctl.sv
// MCU data memory controller: clear sweep FSM, request acceptance, range check,
// and the rvalid/err strobes, wrapped around the mc_mem_array storage.
module data_mem_ctl
  import mc_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_ctl_if.slave  bus
);

  localparam logic [ADDR_W:0]   DepthW  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  mem_state_e        r_state;
  mem_state_e        w_state_d;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [ADDR_W-1:0] w_clr_ptr_d;
  logic              r_rvalid;
  logic              r_err;

  logic              w_ready;
  logic              w_accept;
  logic              w_in_range;
  logic              w_clearing;
  logic              w_req_we;
  logic              w_req_re;
  logic              w_arr_we;
  logic [ADDR_W-1:0] w_arr_waddr;
  logic [DATA_W-1:0] w_arr_wdata;
  logic [DATA_W-1:0] w_arr_rdata;

  assign w_clearing = (r_state == StClear);
  assign w_ready    = (r_state == StIdle);
  // A clear request in the same cycle as an access wins and drops the access.
  assign w_accept   = bus.en & w_ready & ~bus.clr;
  assign w_in_range = ({1'b0, bus.addr} < DepthW);
  assign w_req_we   = w_accept & bus.we & w_in_range;
  assign w_req_re   = w_accept & ~bus.we & w_in_range;

  // Write port is owned by the sweep while clearing, by the request otherwise.
  assign w_arr_we    = w_clearing | w_req_we;
  assign w_arr_waddr = w_clearing ? r_clr_ptr : bus.addr;
  assign w_arr_wdata = w_clearing ? '0 : bus.wdata;

  always_comb begin
    w_state_d   = r_state;
    w_clr_ptr_d = r_clr_ptr;
    unique case (r_state)
      StClear: begin
        if (bus.clr) begin
          w_clr_ptr_d = '0;
        end else if (r_clr_ptr == LastPtr) begin
          w_state_d   = StIdle;
          w_clr_ptr_d = '0;
        end else begin
          w_clr_ptr_d = r_clr_ptr + 1'b1;
        end
      end
      StIdle: begin
        if (bus.clr) begin
          w_state_d   = StClear;
          w_clr_ptr_d = '0;
        end
      end
      default: begin
        w_state_d   = StClear;
        w_clr_ptr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StClear;
      r_clr_ptr <= '0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_clr_ptr <= w_clr_ptr_d;
      r_rvalid  <= w_req_re;
      r_err     <= w_accept & ~w_in_range;
    end
  end

  mc_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_arr_we),
    .i_waddr (w_arr_waddr),
    .i_wdata (w_arr_wdata),
    .i_re    (w_req_re),
    .i_raddr (bus.addr),
    .o_rdata (w_arr_rdata)
  );

  assign bus.ready  = w_ready;
  assign bus.rdata  = w_arr_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.err    = r_err;

  ap_depth_legal: assert property (@(posedge clk) depth_legal(DEPTH, ADDR_W))
    else $fatal(1, "data_mem_ctl: illegal DEPTH %0d for ADDR_W %0d", DEPTH, ADDR_W);

endmodule

// File: tb/tb_data_mem_ctl.sv
// Scoreboard bench for data_mem_ctl (DATA_W=8, ADDR_W=4, DEPTH=12): directed scenarios
// followed by random traffic against an array-and-countdown reference model.
module tb_data_mem_ctl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned DP = 12;

  typedef struct packed {
    logic          is_err;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;

  data_mem_ctl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  data_mem_ctl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_chk;
  int unsigned   n_pass;
  exp_t          sb_q[$];
  logic [DW-1:0] mem_m [DP];
  int unsigned   m_busy;
  logic [DW-1:0] exp_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // One bus cycle: check ready, drive the request, then advance the reference model.
  task automatic cyc(input bit en, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input bit c);
    exp_t e;
    @(negedge clk);
    chk("ready", 32'(bus.ready), 32'(m_busy == 0));
    bus.en = en; bus.we = we; bus.addr = a; bus.wdata = d; bus.clr = c;
    if (m_busy == 0 && en && !c) begin
      if (int'(a) < DP) begin
        if (we) mem_m[a] = d;
        else begin
          e.is_err = 1'b0; e.data = mem_m[a]; sb_q.push_back(e);
        end
      end else begin
        e.is_err = 1'b1; e.data = '0; sb_q.push_back(e);
      end
    end
    if (c) begin
      m_busy = DP;
      for (int i = 0; i < int'(DP); i++) mem_m[i] = '0;
    end else if (m_busy > 0) begin
      m_busy--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #1 rst_n = 1'b0;
    bus.en = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.clr = 1'b0;
    #1;
    chk("rst_ready",  32'(bus.ready),  32'(0));
    chk("rst_rvalid", 32'(bus.rvalid), 32'(0));
    chk("rst_err",    32'(bus.err),    32'(0));
    chk("rst_rdata",  32'(bus.rdata),  32'(0));
    sb_q.delete();
    exp_rdata = '0;
    for (int i = 0; i < int'(DP); i++) mem_m[i] = '0;
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
    m_busy = DP;
  endtask

  // Monitor: pops an expectation whenever the DUT presents rvalid or err.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.rvalid || bus.err) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_strobe", {30'd0, bus.rvalid, bus.err}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("err",    32'(bus.err),    32'(e.is_err));
          chk("rvalid", 32'(bus.rvalid), 32'(!e.is_err));
          if (!e.is_err) exp_rdata = e.data;
          chk("rdata", 32'(bus.rdata), 32'(exp_rdata));
        end
      end else begin
        chk("rdata_hold", 32'(bus.rdata), 32'(exp_rdata));
      end
    end
  end

  initial begin
    n_chk = 0; n_pass = 0; m_busy = DP; exp_rdata = '0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.clr = 1'b0;

    // 1: reset sweep then all words read as zero
    do_reset(3);
    idle(DP);
    for (int a = 0; a < int'(DP); a++) cyc(1'b1, 1'b0, AW'(a), '0, 1'b0);
    idle(2);

    // 2: write then read next cycle
    cyc(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0);
    cyc(1'b1, 1'b0, 4'd3, '0, 1'b0);
    idle(2);

    // 3: back-to-back reads, then rdata holds
    cyc(1'b1, 1'b1, 4'd4, 8'h11, 1'b0);
    cyc(1'b1, 1'b1, 4'd5, 8'h22, 1'b0);
    cyc(1'b1, 1'b0, 4'd4, '0, 1'b0);
    cyc(1'b1, 1'b0, 4'd5, '0, 1'b0);
    idle(3);

    // 4: out-of-range write and read, then no aliasing
    cyc(1'b1, 1'b1, 4'd13, 8'hFF, 1'b0);
    cyc(1'b1, 1'b0, 4'd13, '0, 1'b0);
    cyc(1'b1, 1'b0, 4'd1, '0, 1'b0);
    cyc(1'b1, 1'b0, 4'd3, '0, 1'b0);
    idle(2);

    // 5: clear wins over a simultaneous write
    cyc(1'b1, 1'b1, 4'd3, 8'h5A, 1'b1);
    idle(DP);
    cyc(1'b1, 1'b0, 4'd3, '0, 1'b0);
    idle(2);

    // 6: reset in the middle of a clear sweep
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    idle(6);
    do_reset(2);
    idle(DP);
    cyc(1'b1, 1'b0, 4'd0, '0, 1'b0);
    idle(2);

    // Random traffic including clears and out-of-range addresses
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)),
          DW'($urandom), ($urandom_range(39, 0) == 0));
    end
    idle(DP + 3);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
